// File: rtl/popcount_arbiter.sv
// popcount_arbiter
//   Round-robin scheduler that shares one external bit-count datapath among
//   NUM_REQ requesters. In IDLE it picks the next pending requester after the
//   last winner, acknowledges it combinationally and loads its word into the
//   datapath. It also clears the datapath counter. In COUNT it repeatedly
//   clears the lowest set bit of the datapath number and increments the
//   counter until the number is zero. It then returns the count with a
//   one-cycle one-hot done pulse to the winner.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req             per-requester request level, held until ack
//   req_data        flat request words, requester i at [i*WIDTH +: WIDTH]
//   ack             one-hot combinational accept (IDLE only)
//   done            one-hot registered result-valid pulse
//   result          registered bit count, held until the next done
//   result_id       registered index of the requester owning result
//   busy            high while an operation is in flight
//   dp_in           word routed to the datapath input
//   dp_en_num/ctr   datapath register enables
//   dp_sel_num/ctr  datapath mux selects (0 = load/clear, 1 = step)
//   dp_is_num_zero  datapath number-register zero flag
//   dp_out          datapath counter value
module popcount_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    localparam int CW = $clog2(WIDTH + 1),
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         done,
    output logic [CW-1:0]              result,
    output logic [IW-1:0]              result_id,
    output logic                       busy,
    output logic [WIDTH-1:0]           dp_in,
    output logic                       dp_en_num,
    output logic                       dp_en_ctr,
    output logic                       dp_sel_num,
    output logic                       dp_sel_ctr,
    input  logic                       dp_is_num_zero,
    input  logic [CW-1:0]              dp_out
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_COUNT = 1'b1;

    logic [0:0]         r_state;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_gnt;
    logic [NUM_REQ-1:0] r_done;
    logic [CW-1:0]      r_result;
    logic [IW-1:0]      r_result_id;

    logic [WIDTH-1:0]   w_words [NUM_REQ];
    logic               w_found;
    logic [IW-1:0]      w_grant;
    logic [IW-1:0]      w_cand;
    logic [0:0]         w_next;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_words[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Rotating priority: scan from the slot after the last winner, with wrap,
    // so the most recently served requester is considered last.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = IW'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    always_comb begin
        ack        = '0;
        dp_in      = w_words[0];
        dp_en_num  = 1'b0;
        dp_en_ctr  = 1'b0;
        dp_sel_num = 1'b0;
        dp_sel_ctr = 1'b0;
        w_next     = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    // Load the winner's word and clear the counter in one cycle.
                    ack       = onehot(w_grant);
                    dp_in     = w_words[w_grant];
                    dp_en_num = 1'b1;
                    dp_en_ctr = 1'b1;
                    w_next    = S_COUNT;
                end
            end
            S_COUNT: begin
                dp_in = w_words[r_gnt];
                if (!dp_is_num_zero) begin
                    dp_en_num  = 1'b1;
                    dp_sel_num = 1'b1;
                    dp_en_ctr  = 1'b1;
                    dp_sel_ctr = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= IW'(NUM_REQ - 1);
            r_gnt       <= '0;
            r_done      <= '0;
            r_result    <= '0;
            r_result_id <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= '0;
            // Pointer moves only on an actual grant.
            if (r_state == S_IDLE && w_found) begin
                r_gnt <= w_grant;
                r_ptr <= w_grant;
            end
            if (r_state == S_COUNT && dp_is_num_zero) begin
                r_result    <= dp_out;
                r_result_id <= r_gnt;
                r_done      <= onehot(r_gnt);
            end
        end
    end

    assign done      = r_done;
    assign result    = r_result;
    assign result_id = r_result_id;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_popcount_arbiter.sv
module tb_popcount_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 4;
    localparam int IW = 2;

    logic                clk;
    logic                rst;
    logic [N-1:0]        req;
    logic [N*W-1:0]      req_data;
    logic [N-1:0]        ack;
    logic [N-1:0]        done;
    logic [CW-1:0]       result;
    logic [IW-1:0]       result_id;
    logic                busy;
    logic [W-1:0]        dp_in;
    logic                dp_en_num, dp_en_ctr, dp_sel_num, dp_sel_ctr;
    logic                dp_is_num_zero;
    logic [CW-1:0]       dp_out;

    popcount_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack), .done(done), .result(result), .result_id(result_id),
        .busy(busy), .dp_in(dp_in),
        .dp_en_num(dp_en_num), .dp_en_ctr(dp_en_ctr),
        .dp_sel_num(dp_sel_num), .dp_sel_ctr(dp_sel_ctr),
        .dp_is_num_zero(dp_is_num_zero), .dp_out(dp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural bit-count datapath sharing the same reset.
    logic [W-1:0]  dp_num;
    logic [CW-1:0] dp_ctr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_num <= '0;
            dp_ctr <= '0;
        end else begin
            if (dp_en_num) dp_num <= dp_sel_num ? (dp_num & (dp_num - 8'd1)) : dp_in;
            if (dp_en_ctr) dp_ctr <= dp_sel_ctr ? (dp_ctr + 4'd1) : 4'd0;
        end
    end
    assign dp_is_num_zero = (dp_num == '0);
    assign dp_out         = dp_ctr;

    typedef struct {
        logic [N-1:0] mask;
        int           id;
        logic [W-1:0] word;
        int           lat;
        int           res;
    } vec_t;

    typedef struct {
        int id;
        int cnt;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic logic [N-1:0] oh(input int id);
        return 4'b0001 << id;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_word(input int id, input logic [W-1:0] w);
        req_data[id*W +: W] = w;
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("ack_onehot0", 32'($onehot0(ack)), 1);
            check("done_onehot0", 32'($onehot0(done)), 1);
            if (ack != '0) check("ack_only_idle", 32'(busy), 0);
            if (done != '0) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", 32'(done), 0);
                end else begin
                    e = sbq.pop_front();
                    check("done_vec", 32'(done), 32'(oh(e.id)));
                    check("result", 32'(result), e.cnt);
                    check("result_id", 32'(result_id), e.id);
                end
            end
        end
    end

    // Drive one request mask, expect requester id to win, wait for its done.
    task automatic run_one(input logic [N-1:0] mask, input int id, input logic [W-1:0] word,
                           input int lat, input int res);
        int c;
        bit seen;
        set_word(id, word);
        req = mask;
        @(negedge clk);
        check("ack", 32'(ack), 32'(oh(id)));
        check("load_ctrl", {28'd0, dp_en_num, dp_sel_num, dp_en_ctr, dp_sel_ctr}, 32'b1010);
        check("dp_in", 32'(dp_in), 32'(word));
        sbq.push_back('{id, res});
        @(posedge clk); #1;
        req = '0;
        c = 0;
        seen = 1'b0;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
            if (done != '0) seen = 1'b1;
            else check("busy", 32'(busy), 1);
        end
        check("latency", seen ? c : -1, lat);
        check("busy_done", 32'(busy), 0);
        @(negedge clk);
        check("done_pulse", 32'(done), 0);
        @(posedge clk); #1;
    endtask

    // Hold a request mask (all words 8'h01) and expect a grant sequence.
    task automatic run_held(input logic [N-1:0] mask, input int n, input int ids[8]);
        int c;
        bit got;
        for (int i = 0; i < N; i++) set_word(i, 8'h01);
        req = mask;
        for (int k = 0; k < n; k++) begin
            c = 0;
            got = 1'b0;
            while (!got && c < 12) begin
                @(negedge clk);
                c++;
                if (ack != '0) got = 1'b1;
            end
            check("held_ack", 32'(ack), 32'(oh(ids[k])));
            if (k > 0) check("held_gap", c, 3);
            if (got) sbq.push_back('{ids[k], 1});
        end
        @(posedge clk); #1;
        req = '0;
        repeat (6) @(negedge clk);
        check("sb_drain", sbq.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   c;
        bit   seen;
        tbl[0] = '{4'b0001, 0, 8'hB5, 7, 5};
        tbl[1] = '{4'b0100, 2, 8'h00, 2, 0};
        tbl[2] = '{4'b0100, 2, 8'hFF, 10, 8};
        tbl[3] = '{4'b0010, 1, 8'h01, 3, 1};
        tbl[4] = '{4'b1000, 3, 8'h80, 3, 1};
        tbl[5] = '{4'b0110, 1, 8'hAA, 6, 4};
        tbl[6] = '{4'b1001, 3, 8'h7F, 9, 7};

        rst      = 1'b1;
        req      = '0;
        req_data = 32'h44332211;
        @(negedge clk);
        check("rst_ack", 32'(ack), 0);
        check("rst_done", 32'(done), 0);
        check("rst_result", 32'(result), 0);
        check("rst_result_id", 32'(result_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dp_ctrl", {28'd0, dp_en_num, dp_sel_num, dp_en_ctr, dp_sel_ctr}, 0);
        check("idle_dp_in", 32'(dp_in), 32'h11);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single requests, corner words and simple contention
        for (int i = 0; i < 7; i++) begin
            run_one(tbl[i].mask, tbl[i].id, tbl[i].word, tbl[i].lat, tbl[i].res);
        end

        // Full rotation from reset
        do_reset();
        run_held(4'b1111, 5, '{0, 1, 2, 3, 0, 0, 0, 0});

        // Two contenders after last grant 1
        run_one(4'b0010, 1, 8'h01, 3, 1);
        run_held(4'b1010, 4, '{3, 1, 3, 1, 0, 0, 0, 0});

        // Back-to-back: new ack in the done cycle
        set_word(1, 8'h01);
        req = 4'b0010;
        @(negedge clk);
        check("b2b_ack0", 32'(ack), 32'b0010);
        sbq.push_back('{1, 1});
        repeat (3) begin
            @(posedge clk); #1;
        end
        set_word(1, 8'h03);
        @(negedge clk);
        check("b2b_done", 32'(done), 32'b0010);
        check("b2b_ack1", 32'(ack), 32'b0010);
        check("b2b_dp_in", 32'(dp_in), 32'h03);
        sbq.push_back('{1, 2});
        @(posedge clk); #1;
        req = '0;
        c = 0;
        seen = 1'b0;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
            if (done != '0) seen = 1'b1;
        end
        check("b2b_latency", seen ? c : -1, 4);
        @(posedge clk); #1;

        // Reset mid-count abandons the operation
        set_word(2, 8'hFF);
        req = 4'b0100;
        @(negedge clk);
        check("mid_ack", 32'(ack), 32'b0100);
        @(posedge clk); #1;
        req = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("busy_pre_rst", 32'(busy), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_result", 32'(result), 0);
        check("mid_rst_done", 32'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("post_rst_result", 32'(result), 0);
        check("post_rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        set_word(2, 8'h55);
        run_one(4'b0101, 0, 8'h0F, 6, 4);
        check("final_sb_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
